// File: rtl/sa_job_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sa_job_sequencer_if
//  Description : Handshake bundle between the job sequencer, its host/DMA
//                command source, the operand stream, the systolic-array core
//                and the result sink.
//                slave  modport : the sequencer side
//                master modport : the environment side (host, core, sink)
//  Signals     : cmd_valid/cmd_ready/cmd_k     job command handshake
//                src_valid/src_ready           operand beat handshake
//                core_inpvalid/core_outread    strobes into the core
//                core_rvalid                   per-column result valid
//                sink_valid/sink_ready/sink_idx result vector handshake
//                busy/done/err/perf_cycles     status
//  Revision    : 1.0  initial release
// ============================================================================
interface sa_job_sequencer_if #(
  parameter int ROWS = 8,
  parameter int KW   = 16
);
  localparam int c_iw = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [KW-1:0]   cmd_k;
  logic            src_valid;
  logic            src_ready;
  logic            core_inpvalid;
  logic [ROWS-1:0] core_rvalid;
  logic            core_outread;
  logic            sink_valid;
  logic            sink_ready;
  logic [c_iw-1:0] sink_idx;
  logic            busy;
  logic            done;
  logic            err;
  logic [31:0]     perf_cycles;

  modport slave (
    input  cmd_valid, cmd_k, src_valid, core_rvalid, sink_ready,
    output cmd_ready, src_ready, core_inpvalid, core_outread,
           sink_valid, sink_idx, busy, done, err, perf_cycles
  );

  modport master (
    output cmd_valid, cmd_k, src_valid, core_rvalid, sink_ready,
    input  cmd_ready, src_ready, core_inpvalid, core_outread,
           sink_valid, sink_idx, busy, done, err, perf_cycles
  );
endinterface
`default_nettype wire

// File: rtl/sa_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sa_job_sequencer
//  Description : Job-level controller in front of the systolic-array core.
//                Accepts one matrix job per command, gates the operand stream
//                into the core, waits for all column buffers to fill, then
//                unloads ROWS result vectors to the sink and pulses done.
//                Operand/result data bypass this block.
//  Ports       : clk   clock, all logic on posedge
//                rstn  asynchronous active-low reset
//                bus   sa_job_sequencer_if.slave (command, operand, core,
//                      sink and status signals)
//  Parameters  : ROWS     array dimension / vectors unloaded per job
//                KW       width of the job depth field cmd_k
//                TIMEOUT  cycles allowed waiting for all-ones core_rvalid
//  Options     : SA_SEQ_PERF_EN  when defined, perf_cycles counts cycles
//                from command handshake to done pulse (both inclusive);
//                otherwise perf_cycles is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module sa_job_sequencer #(
  parameter int ROWS    = 8,
  parameter int KW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  sa_job_sequencer_if.slave    bus
);

  localparam int c_iw = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_vw = $clog2(ROWS) + 1;
  localparam int c_ww = $clog2(TIMEOUT) + 1;

  localparam logic [c_vw-1:0] c_vec_last  = c_vw'(ROWS - 1);
  localparam logic [c_ww-1:0] c_wait_last = c_ww'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DRAIN  = 3'd2,
    S_UNLOAD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   r_beat_cnt;
  logic [c_vw-1:0] r_vec_cnt;
  logic [c_ww-1:0] r_wait_cnt;
  logic            r_cmd_ready;
  logic            r_src_ready;
  logic            r_unload;
  logic            r_busy;
  logic            r_done;
  logic            r_err;

  logic w_all_valid;
  logic w_cmd_fire;
  logic w_src_fire;
  logic w_sink_valid;
  logic w_sink_fire;
  logic w_wait_exp;

  assign w_all_valid  = &bus.core_rvalid;
  assign w_cmd_fire   = bus.cmd_valid & r_cmd_ready;
  assign w_src_fire   = bus.src_valid & r_src_ready;
  // Result vector is only offered while unloading and all columns are full,
  // so a partial core_rvalid never leaks to the sink.
  assign w_sink_valid = r_unload & w_all_valid;
  assign w_sink_fire  = w_sink_valid & bus.sink_ready;
  assign w_wait_exp   = (r_wait_cnt == c_wait_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_beat_cnt  <= '0;
      r_vec_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_cmd_ready <= 1'b0;
      r_src_ready <= 1'b0;
      r_unload    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cmd_ready comes up one cycle after reset release.
          r_cmd_ready <= 1'b1;
          if (w_cmd_fire) begin
            r_k         <= bus.cmd_k;
            r_err       <= 1'b0;
            r_beat_cnt  <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (bus.cmd_k == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_LOAD;
              r_src_ready <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (w_src_fire) begin
            r_beat_cnt <= r_beat_cnt + KW'(1);
            if (r_beat_cnt == r_k - KW'(1)) begin
              r_state     <= S_DRAIN;
              r_src_ready <= 1'b0;
              r_wait_cnt  <= '0;
            end
          end
        end

        S_DRAIN: begin
          if (w_all_valid) begin
            r_state    <= S_UNLOAD;
            r_unload   <= 1'b1;
            r_vec_cnt  <= '0;
            r_wait_cnt <= '0;
          end else if (w_wait_exp) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_ww'(1);
          end
        end

        S_UNLOAD: begin
          if (w_sink_fire) begin
            r_vec_cnt  <= r_vec_cnt + c_vw'(1);
            r_wait_cnt <= '0;
            if (r_vec_cnt == c_vec_last) begin
              r_state  <= S_DONE;
              r_unload <= 1'b0;
              r_done   <= 1'b1;
            end
          end else if (!w_all_valid) begin
            // Only a starved core counts toward timeout; a stalled sink does not.
            if (w_wait_exp) begin
              r_state  <= S_DONE;
              r_unload <= 1'b0;
              r_err    <= 1'b1;
              r_done   <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + c_ww'(1);
            end
          end
        end

        S_DONE: begin
          // Raise cmd_ready together with the return to IDLE so the next
          // command can be taken in the cycle right after done.
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.src_ready     = r_src_ready;
  assign bus.core_inpvalid = w_src_fire;
  assign bus.core_outread  = w_sink_fire;
  assign bus.sink_valid    = w_sink_valid;
  assign bus.sink_idx      = r_vec_cnt[c_iw-1:0];
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err           = r_err;

`ifdef SA_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Handshake cycle loads 1; every following non-IDLE cycle (through DONE)
  // adds one, so the value seen in IDLE covers handshake..done inclusive.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf <= '0;
    end else if (w_cmd_fire) begin
      r_perf <= 32'd1;
    end else if (r_state != S_IDLE) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf;
`else
  assign bus.perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sa_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_job_sequencer
//  Description : Self-checking bench for sa_job_sequencer. Expected unload
//                indices go into a scoreboard queue when the core model
//                raises core_rvalid and are popped on every core_outread.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sa_job_sequencer;

  localparam int ROWS = 8;
  localparam int KW   = 16;
  localparam int TMO  = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;

  int n_tests = 0;
  int n_fail  = 0;

  int   q_idx[$];
  int   n_inp        = 0;
  int   n_srcrdy     = 0;
  bit   exp_done_nxt = 1'b0;
  bit   hold_prev    = 1'b0;
  int   idx_prev     = 0;

  sa_job_sequencer_if #(.ROWS(ROWS), .KW(KW)) bus ();

  sa_job_sequencer #(.ROWS(ROWS), .KW(KW), .TIMEOUT(TMO)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: counts strobes and pops the scoreboard on each unloaded vector.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.core_inpvalid) n_inp++;
      if (bus.src_ready) n_srcrdy++;
      if (exp_done_nxt) begin
        check_eq("done_lat", bus.done, 1);
        exp_done_nxt = 1'b0;
      end
      if (hold_prev) begin
        check_eq("hold_valid", bus.sink_valid, 1);
        check_eq("hold_idx", bus.sink_idx, idx_prev);
      end
      if (bus.core_outread) begin
        check_eq("outread_valid", bus.sink_valid, 1);
        if (q_idx.size() == 0) begin
          check_eq("outread_unexp", q_idx.size(), 1);
        end else begin
          int e;
          e = q_idx.pop_front();
          check_eq("sink_idx", bus.sink_idx, e);
          if (q_idx.size() == 0) exp_done_nxt = 1'b1;
        end
      end
      hold_prev = bus.sink_valid & ~bus.sink_ready;
      idx_prev  = int'(bus.sink_idx);
    end else begin
      hold_prev    = 1'b0;
      exp_done_nxt = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int k, input bit gaps, input bit toggle, input bit stuck);
    int hs_cyc, last_cyc, done_cyc, sent, inp0, srdy0, budget;
    last_cyc = 0;
    inp0     = n_inp;
    srdy0    = n_srcrdy;
    budget   = 0;
    while (!bus.cmd_ready && budget < 50) begin
      tick();
      budget++;
    end
    check_eq("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = KW'(k);
    hs_cyc        = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("err_clr", bus.err, 0);
    check_eq("busy", bus.busy, 1);
    if (k == 0) begin
      check_eq("zero_done", bus.done, 1);
      done_cyc = cyc;
    end else begin
      check_eq("src_rdy_lat", bus.src_ready, 1);
      sent   = 0;
      budget = 0;
      while (sent < k && budget < 500) begin
        bus.src_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (bus.src_valid && bus.src_ready) begin
          sent++;
          last_cyc = cyc;
        end
        tick();
        budget++;
      end
      // Keep offering beats after LOAD in the gapped run; none may reach the core.
      bus.src_valid = gaps;
      check_eq("beats_sent", sent, k);
      check_eq("src_rdy_drop", bus.src_ready, 0);
      repeat (4) tick();
      bus.core_rvalid = stuck ? {1'b0, {(ROWS-1){1'b1}}} : {ROWS{1'b1}};
      if (!stuck) for (int i = 0; i < ROWS; i++) q_idx.push_back(i);
      bus.src_valid  = 1'b0;
      bus.sink_ready = 1'b1;
      budget = 0;
      while (!bus.done && budget < 300) begin
        tick();
        budget++;
        if (toggle) bus.sink_ready = ~bus.sink_ready;
      end
      check_eq("done_seen", bus.done, 1);
      done_cyc = cyc;
      check_eq("err", bus.err, stuck);
      if (stuck) check_eq("tmo_lat", done_cyc - last_cyc, TMO + 1);
      check_eq("inp_cnt", n_inp - inp0, k);
      check_eq("outread_left", q_idx.size(), 0);
    end
    if (k == 0) check_eq("no_src_rdy", n_srcrdy - srdy0, 0);
    tick();
    check_eq("done_pulse", bus.done, 0);
    check_eq("cmd_rdy_after", bus.cmd_ready, 1);
    check_eq("busy_idle", bus.busy, 0);
    check_eq("err_hold", bus.err, stuck);
`ifdef SA_SEQ_PERF_EN
    check_eq("perf", bus.perf_cycles, done_cyc - hs_cyc + 1);
`else
    check_eq("perf_off", bus.perf_cycles, 0);
`endif
    bus.core_rvalid = '0;
    bus.sink_ready  = 1'b0;
    q_idx.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    check_eq({tag, "_src_ready"}, bus.src_ready, 0);
    check_eq({tag, "_inpvalid"}, bus.core_inpvalid, 0);
    check_eq({tag, "_outread"}, bus.core_outread, 0);
    check_eq({tag, "_sink_valid"}, bus.sink_valid, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_done"}, bus.done, 0);
    check_eq({tag, "_err"}, bus.err, 0);
    check_eq({tag, "_perf"}, bus.perf_cycles, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_k       = '0;
    bus.src_valid   = 1'b0;
    bus.core_rvalid = '0;
    bus.sink_ready  = 1'b0;
    rstn            = 1'b0;
    repeat (3) tick();
    check_all_zero("rst");
    rstn = 1'b1;
    check_eq("cmd_rdy_pre", bus.cmd_ready, 0);
    tick();
    check_eq("cmd_rdy_post", bus.cmd_ready, 1);

    // Abort a job mid-LOAD with reset.
    bus.cmd_valid = 1'b1;
    bus.cmd_k     = KW'(4);
    tick();
    bus.cmd_valid = 1'b0;
    bus.src_valid = 1'b1;
    repeat (2) tick();
    check_eq("mid_load_inp", bus.core_inpvalid, 1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("abort");
    bus.src_valid = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("abort_no_done", bus.done, 0);
      check_eq("abort_cmd_rdy", bus.cmd_ready, 1);
    end

    run_job(3, 1'b0, 1'b0, 1'b0);   // nominal
    run_job(4, 1'b1, 1'b1, 1'b0);   // operand gaps and sink backpressure
    run_job(2, 1'b0, 1'b0, 1'b1);   // DRAIN timeout, err set
    run_job(0, 1'b0, 1'b0, 1'b0);   // zero job, clears err
    run_job(1, 1'b1, 1'b1, 1'b0);   // single beat

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
